apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Shares the single APB master datapath (apb_topmodule command interface: transfer, read_write, write/read address, write data; pready/pslverr/prdata back) between NREQ requesters.
- Round-robin arbitration; the winner's command is latched and held on the master interface until pready; the response is routed back with a one-cycle done pulse.
- Sits between the firmware-facing request ports and apb_topmodule.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 8, APB address width.
- DW, 8, APB data width.
- TO_CYCLES, 16, WAIT-state timeout limit; used only with the optional feature.

Ports:
- pclk  in  1  clock; all logic is rising-edge.
- presetn  in  1  reset, synchronous, active-high. The name follows codebase convention; polarity is high.
- req  in  NREQ  per-requester request level.
- req_rw  in  NREQ  per-requester direction: 1 = write, 0 = read.
- req_addr  in  NREQ*AW  flattened addresses; requester i occupies [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DW  read data; valid while done is nonzero.
- rsp_err  out  1  slave error; valid while done is nonzero.
- busy  out  1  high in any state except IDLE.
- m_transfer  out  1  to apb_topmodule transfer.
- m_read_write  out  1  to apb_topmodule read_write.
- m_write_paddr  out  AW  to apb_topmodule write address.
- m_read_paddr  out  AW  to apb_topmodule read address.
- m_write_data  out  DW  to apb_topmodule write data.
- m_pready  in  1  from apb_topmodule.
- m_pslverr  in  1  from apb_topmodule.
- m_prdata  in  DW  from apb_topmodule.

Behaviour:
- Reset (presetn=1 at a pclk edge):
  - state=IDLE; all outputs 0.
  - last_grant = NREQ-1, so requester 0 wins first.
  - Reset mid-transfer drops m_transfer the next cycle. No done pulse is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req != 0, grant the first set bit searching from last_grant+1 with wrap-around.
  - Latch grant, rw, addr and wdata into command registers; go to WAIT.
  - m_transfer rises one cycle after req is sampled.
- WAIT:
  - m_transfer=1; m_read_write, addresses and data are driven from the latched command and are stable throughout.
  - A write drives m_write_paddr and leaves m_read_paddr at 0; a read is the reverse. m_write_data is 0 for reads.
  - On m_pready=1: capture m_prdata (reads; 0 for writes) and m_pslverr; drop m_transfer next cycle; go to RESP.
- RESP (one cycle):
  - done[grant]=1, rsp_rdata and rsp_err valid; last_grant := grant; return to IDLE.
  - The earliest re-arbitration is the following cycle, so back-to-back transfers have one idle cycle between m_transfer pulses.
- Requester rules:
  - req is a level and must stay high until done is seen.
  - Deasserting req after grant does not abort; the transfer completes and done still pulses.
  - Requester must drop or refresh req in the cycle done is seen. If req stays high, a new transfer is issued when next granted.
- Fairness:
  - Simultaneous requests are resolved by round-robin.
  - A continuously requesting master waits at most NREQ-1 transfers.
- Command inputs from non-granted requesters are ignored; command inputs change while in WAIT have no effect.
- m_pready outside WAIT is ignored.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TO_CYCLES with no m_pready, m_transfer drops and the FSM goes to RESP with rsp_err=1 and rsp_rdata=0.
  - m_pready in the same cycle as the limit wins, giving a normal completion.
- Undefined: no counter; WAIT is held indefinitely until m_pready.

Decomposition:
- Shared package apb_arb_pkg:
  - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - default AW/DW constants.
- One sub-module, apb_rr_picker: combinational round-robin picker. Inputs req and last_grant; outputs one-hot grant and its index.

Test Plan:
- Single write: req[0]=1, rw=1, addr=8'h15, wdata=8'hA5.
  - m_transfer rises next cycle with m_write_paddr=8'h15, m_write_data=8'hA5.
  - pready after 2 cycles → done[0] pulses one cycle, rsp_err=0.
- Read-back: req[1] read of 8'h15, slave returns 8'hA5 → rsp_rdata=8'hA5 with done[1]; m_read_paddr=8'h15 and m_write_paddr=0 in WAIT.
- Contention: req=2'b11 held continuously.
  - Grants alternate 0,1,0,1 over 4 transfers.
  - Never two consecutive grants to one requester.
  - One idle cycle between m_transfer pulses.
- Slave error: m_pslverr=1 with pready on a write to 8'h30 → rsp_err=1 with done; next transfer rsp_err=0.
- Reset mid-WAIT: presetn=1 while m_transfer=1 → next cycle all outputs 0, no done; after release, requester 0 wins first.
- With APB_ARB_TIMEOUT_EN and TO_CYCLES=16, pready held 0 → done after 16 WAIT cycles with rsp_err=1 and rsp_rdata=0. Without the macro, m_transfer stays high for 100+ cycles.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Purpose: shared types and defaults for the APB requester arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
// Contents: FSM state encoding and the default APB address and data widths.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam int ARB_AW_DEF = 8;
   localparam int ARB_DW_DEF = 8;

endpackage

// File: rtl/apb_rr_picker.sv
// Purpose: combinational round-robin picker over NREQ request lines.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when to use the pick.
// Ports:
//   req        in   NREQ  request lines
//   last_grant in   IW    index of the previous winner
//   grant_oh   out  NREQ  one-hot winner, all zero when req is zero
//   grant_idx  out  IW    index of the winner, 0 when req is zero
module apb_rr_picker #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant_oh,
   output logic [IW-1:0]   grant_idx
);

   logic [IW-1:0] cand;
   logic          found;

   // Walk the candidates starting one past the last winner, wrapping at
   // NREQ-1.  The first set request wins.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = last_grant;
      for (int k = 0; k < NREQ; k++) begin
         cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
         if (!found && req[cand]) begin
            found          = 1'b1;
            grant_idx      = cand;
            grant_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Purpose: round-robin share of one APB master command port between NREQ requesters.
// Latency: m_transfer one cycle after req is sampled; done one cycle after m_pready.
// Backpressure: the command is held on the master port until m_pready; req levels wait unserved meanwhile.
// Ports:
//   pclk, presetn (sync, active-high) | req/req_rw/req_addr/req_wdata: flattened per-requester command
//   done/rsp_rdata/rsp_err: one-cycle response | busy: FSM not idle
//   m_*: command to and response from apb_topmodule
// Option: define APB_ARB_TIMEOUT_EN to end WAIT with an error after TO_CYCLES cycles.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int AW        = ARB_AW_DEF,
   parameter int DW        = ARB_DW_DEF,
   parameter int TO_CYCLES = 16
) (
   input  logic               pclk,
   input  logic               presetn,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_rw,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    done,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic               busy,
   output logic               m_transfer,
   output logic               m_read_write,
   output logic [AW-1:0]      m_write_paddr,
   output logic [AW-1:0]      m_read_paddr,
   output logic [DW-1:0]      m_write_data,
   input  logic               m_pready,
   input  logic               m_pslverr,
   input  logic [DW-1:0]      m_prdata
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1) begin : g_bad_cfg
      $error("apb_req_arbiter: NREQ must be 2..8 and TO_CYCLES at least 1");
   end

   arb_state_e    state_q, state_d;
   logic [IW-1:0] last_grant_q, last_grant_d;
   logic [IW-1:0] gnt_q, gnt_d;
   logic          rw_q, rw_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [NREQ-1:0] pick_oh;
   logic [IW-1:0]   pick_idx;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   apb_rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .req        (req),
      .last_grant (last_grant_q),
      .grant_oh   (pick_oh),
      .grant_idx  (pick_idx)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (|pick_oh) begin
               // Only the winner's command is captured; later input changes
               // cannot disturb the transfer in flight.
               gnt_d   = pick_idx;
               rw_d    = req_rw[pick_idx];
               addr_d  = req_addr[pick_idx*AW +: AW];
               wdata_d = req_wdata[pick_idx*DW +: DW];
               state_d = WAIT;
`ifdef APB_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         WAIT: begin
            // m_pready takes priority over the timeout in the same cycle.
            if (m_pready) begin
               rdata_d = rw_q ? '0 : m_prdata;
               err_d   = m_pslverr;
               state_d = RESP;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TO_CYCLES - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         RESP: begin
            last_grant_d = gnt_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (presetn) begin
         state_q      <= IDLE;
         last_grant_q <= IW'(NREQ - 1);
         gnt_q        <= '0;
         rw_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   // Every output is a gate of registered state, so reset forces all of
   // them to zero on the following cycle.
   always_comb begin
      busy          = (state_q != IDLE);
      m_transfer    = (state_q == WAIT);
      m_read_write  = m_transfer & rw_q;
      m_write_paddr = (m_transfer &&  rw_q) ? addr_q  : '0;
      m_read_paddr  = (m_transfer && !rw_q) ? addr_q  : '0;
      m_write_data  = (m_transfer &&  rw_q) ? wdata_q : '0;
      done          = (state_q == RESP) ? (NREQ'(1) << gnt_q) : '0;
      rsp_rdata     = (state_q == RESP) ? rdata_q : '0;
      rsp_err       = (state_q == RESP) & err_q;
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Purpose: directed self-checking bench for apb_req_arbiter with NREQ=2, AW=DW=8.
// Latency: inputs driven and outputs sampled 1 time unit after each rising pclk edge.
// Backpressure: m_pready is driven by hand to shape each WAIT phase.
module tb_apb_req_arbiter;

   logic        pclk = 1'b0;
   logic        presetn;
   logic [1:0]  req, req_rw, done;
   logic [15:0] req_addr, req_wdata;
   logic [7:0]  rsp_rdata, m_write_paddr, m_read_paddr, m_write_data, m_prdata;
   logic        rsp_err, busy, m_transfer, m_read_write, m_pready, m_pslverr;

   int n_chk = 0;
   int n_err = 0;
   int n;

   always #5 pclk = ~pclk;

   apb_req_arbiter #(
      .NREQ (2), .AW (8), .DW (8), .TO_CYCLES (16)
   ) dut (
      .pclk          (pclk),
      .presetn       (presetn),
      .req           (req),
      .req_rw        (req_rw),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .done          (done),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .busy          (busy),
      .m_transfer    (m_transfer),
      .m_read_write  (m_read_write),
      .m_write_paddr (m_write_paddr),
      .m_read_paddr  (m_read_paddr),
      .m_write_data  (m_write_data),
      .m_pready      (m_pready),
      .m_pslverr     (m_pslverr),
      .m_prdata      (m_prdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   initial begin
      presetn   = 1'b1;
      req       = '0;
      req_rw    = '0;
      req_addr  = '0;
      req_wdata = '0;
      m_pready  = 1'b0;
      m_pslverr = 1'b0;
      m_prdata  = '0;
      tick;
      tick;
      chk("rst_ctl", {28'd0, m_transfer, busy, done}, 32'h0);
      chk("rst_rsp", {23'd0, rsp_err, rsp_rdata}, 32'h0);
      chk("rst_addr", {m_write_paddr, m_read_paddr, m_write_data, 7'd0, m_read_write}, 32'h0);
      presetn = 1'b0;
      tick;
      chk("idle_busy", busy, 0);

      // Single write by requester 0, pready after two WAIT cycles
      req = 2'b01; req_rw = 2'b01; req_addr = 16'h0015; req_wdata = 16'h00A5;
      tick;
      chk("wr_xfer", m_transfer, 1);
      chk("wr_rw", m_read_write, 1);
      chk("wr_waddr", m_write_paddr, 8'h15);
      chk("wr_raddr", m_read_paddr, 8'h00);
      chk("wr_wdata", m_write_data, 8'hA5);
      req_addr = 16'h0077; req_wdata = 16'h0011;
      tick;
      chk("wr_hold_addr", m_write_paddr, 8'h15);
      chk("wr_hold_data", m_write_data, 8'hA5);
      m_pready = 1'b1; m_prdata = 8'h5A;
      tick;
      m_pready = 1'b0;
      chk("wr_done", done, 2'b01);
      chk("wr_err", rsp_err, 0);
      chk("wr_rdata_zero", rsp_rdata, 8'h00);
      chk("wr_xfer_drop", m_transfer, 0);
      req = 2'b00;
      tick;
      chk("wr_done_pulse", done, 2'b00);
      chk("wr_idle", busy, 0);

      // Read-back by requester 1
      req = 2'b10; req_rw = 2'b00; req_addr = 16'h1500; req_wdata = 16'hFF00;
      tick;
      chk("rd_rw", m_read_write, 0);
      chk("rd_raddr", m_read_paddr, 8'h15);
      chk("rd_waddr", m_write_paddr, 8'h00);
      chk("rd_wdata", m_write_data, 8'h00);
      m_pready = 1'b1; m_prdata = 8'hA5;
      tick;
      m_pready = 1'b0;
      chk("rd_done", done, 2'b10);
      chk("rd_rdata", rsp_rdata, 8'hA5);
      chk("rd_err", rsp_err, 0);
      req = 2'b00;
      tick;

      // Contention: last winner was 1, so grants go 0,1,0,1
      req = 2'b11; req_rw = 2'b11; req_addr = 16'h2010;
      tick;
      for (int i = 0; i < 4; i++) begin
         chk("cont_addr", m_write_paddr, (i % 2 == 1) ? 8'h20 : 8'h10);
         m_pready = 1'b1;
         tick;
         m_pready = 1'b0;
         chk("cont_done", done, (i % 2 == 1) ? 2'b10 : 2'b01);
         if (i == 3) req = 2'b00;
         tick;
         chk("cont_gap", m_transfer, 0);
         if (i < 3) tick;
      end

      // Slave error on a write, then a clean read
      req = 2'b01; req_rw = 2'b01; req_addr = 16'h0030;
      tick;
      chk("err_waddr", m_write_paddr, 8'h30);
      m_pready = 1'b1; m_pslverr = 1'b1;
      tick;
      m_pready = 1'b0; m_pslverr = 1'b0;
      chk("err_done", done, 2'b01);
      chk("err_flag", rsp_err, 1);
      req = 2'b00;
      tick;
      req = 2'b10; req_rw = 2'b00; req_addr = 16'h3100;
      tick;
      m_pready = 1'b1; m_prdata = 8'h3C;
      tick;
      m_pready = 1'b0;
      chk("err_next_done", done, 2'b10);
      chk("err_next_flag", rsp_err, 0);
      chk("err_next_rdata", rsp_rdata, 8'h3C);
      req = 2'b00;
      tick;

      // Make requester 0 the last winner, then reset while requester 1 is in WAIT
      req = 2'b01; req_rw = 2'b11; req_addr = 16'h5040;
      tick;
      m_pready = 1'b1;
      tick;
      m_pready = 1'b0;
      chk("pre_rst_done", done, 2'b01);
      req = 2'b00;
      tick;
      req = 2'b11;
      tick;
      chk("pre_rst_grant1", m_write_paddr, 8'h50);
      presetn = 1'b1;
      tick;
      chk("mid_rst_ctl", {28'd0, m_transfer, busy, done}, 32'h0);
      chk("mid_rst_addr", {m_write_paddr, m_write_data}, 32'h0);
      tick;
      chk("mid_rst_nodone", done, 2'b00);
      presetn = 1'b0;
      tick;
      chk("post_rst_xfer", m_transfer, 1);
      chk("post_rst_grant0", m_write_paddr, 8'h40);
      m_pready = 1'b1;
      tick;
      m_pready = 1'b0;
      chk("post_rst_done", done, 2'b01);
      req = 2'b00;
      tick;

      // Slave that never answers
      req = 2'b01; req_rw = 2'b00; req_addr = 16'h0060; m_prdata = 8'hEE;
      tick;
      n = 0;
`ifdef APB_ARB_TIMEOUT_EN
      for (int c = 0; c < 200; c++) begin
         if (done != 2'b00) break;
         if (m_transfer) n++;
         tick;
      end
      chk("to_wait_cycles", n, 16);
      chk("to_done", done, 2'b01);
      chk("to_err", rsp_err, 1);
      chk("to_rdata", rsp_rdata, 8'h00);
      req = 2'b00;
      tick;
      chk("to_idle", m_transfer, 0);
`else
      for (int c = 0; c < 120; c++) begin
         if (m_transfer && done == 2'b00) n++;
         tick;
      end
      chk("hold_cycles", n, 120);
      chk("hold_xfer", m_transfer, 1);
      m_pready = 1'b1;
      tick;
      m_pready = 1'b0;
      chk("hold_done", done, 2'b01);
      chk("hold_err", rsp_err, 0);
      chk("hold_rdata", rsp_rdata, 8'hEE);
      req = 2'b00;
      tick;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
